// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, mid-bit sampling, one-cycle byte strobe.
// Define UART_RX_MAJORITY_EN for a 2-of-3 majority vote at each sample point.
module uart_rx #(
  parameter int CLK_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF = CLK_PER_BIT / 2;
  localparam logic [12:0] HALF_M1 = 13'(HALF - 1);
  localparam logic [12:0] FULL_M1 = 13'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic [12:0] clk_count;
  logic [2:0]  bit_index;
  logic [7:0]  shift;
  logic        sample;

  // two-flop synchronizer, idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // last two synchronized values for the 2-of-3 vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample = (hist[1] & hist[0]) |
                  (hist[1] & rx_s) |
                  (hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  // frame FSM with registered byte and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clk_count  <= '0;
      bit_index  <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state     <= START;
            clk_count <= '0;
          end
        end
        START: begin
          if (clk_count == HALF_M1) begin
            clk_count <= '0;
            if (!sample) begin
              state     <= DATA;
              bit_index <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_count <= clk_count + 13'd1;
          end
        end
        DATA: begin
          if (clk_count == FULL_M1) begin
            clk_count <= '0;
            shift     <= {sample, shift[7:1]};
            if (bit_index == 3'd7) begin
              state <= STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            clk_count <= clk_count + 13'd1;
          end
        end
        STOP: begin
          if (clk_count == FULL_M1) begin
            clk_count <= '0;
            if (sample) begin
              data_out   <= shift;
              data_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            clk_count <= clk_count + 13'd1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: line traces decoded by a timing-rule model.
// Every cycle of each trace is compared against the model.
module tb_uart_rx;

  localparam int CBP  = 16;
  localparam int HALF = CBP / 2;
  localparam int MAXT = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLK_PER_BIT(CBP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  bit       line[$];
  int       ev[MAXT];
  bit [7:0] evd[MAXT];
  bit       eb[MAXT];

  int       n_chk = 0;
  int       n_fail = 0;
  bit [7:0] exp_dout;
  int       vcount, ecount, bcount, first_valid;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) line.push_back(1'b1);
  endtask

  task automatic low(int n);
    repeat (n) line.push_back(1'b0);
  endtask

  task automatic frame(bit [7:0] b, bit stop);
    repeat (CBP) line.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      repeat (CBP) line.push_back(b[i]);
    repeat (CBP) line.push_back(stop);
  endtask

  // value the receiver logic sees at edge e (two flops of delay)
  function automatic bit rs(int e);
    if (e < 2) return 1'b1;
    return line[e-2];
  endfunction

  function automatic bit samp(int e);
`ifdef UART_RX_MAJORITY_EN
    int ones;
    ones = int'(rs(e-2)) + int'(rs(e-1)) + int'(rs(e));
    return ones >= 2;
`else
    return rs(e);
`endif
  endfunction

  task automatic mark(int a, int b);
    for (int i = a; i <= b; i++) eb[i] = 1'b1;
  endtask

  // decode the trace from the frame timing rules
  task automatic build_model();
    int t, e, s, c, st, w;
    bit [7:0] by;
    t = line.size();
    for (int i = 0; i < MAXT; i++) begin
      ev[i] = 0; evd[i] = '0; eb[i] = 1'b0;
    end
    e = 0;
    while (e < t) begin
      if (rs(e)) begin
        e++;
        continue;
      end
      s = e;
      c = s + HALF;
      if (c >= t) begin mark(s, t-1); break; end
      if (samp(c)) begin
        mark(s, c-1);
        e = c + 1;
        continue;
      end
      st = c + 9*CBP;
      if (st >= t) begin mark(s, t-1); break; end
      for (int i = 0; i < 8; i++) by[i] = samp(c + (i+1)*CBP);
      if (samp(st)) begin
        ev[st] = 1; evd[st] = by;
        mark(s, st-1);
        e = st + 1;
      end else begin
        ev[st] = 2;
        w = st + 1;
        while (w < t && !rs(w)) w++;
        mark(s, w-1);
        e = w + 1;
      end
    end
  endtask

  task automatic compare(int k);
    if (k == 0) begin
      exp_dout = '0; vcount = 0; ecount = 0;
      bcount = 0; first_valid = -1;
    end
    if (ev[k] == 1) exp_dout = evd[k];
    check("data_valid", 32'(data_valid), 32'(ev[k] == 1));
    check("frame_err", 32'(frame_err), 32'(ev[k] == 2));
    check("data_out", 32'(data_out), 32'(exp_dout));
    check("busy", 32'(busy), 32'(eb[k]));
    check("exclusive", 32'(data_valid & frame_err), 32'(0));
    if (data_valid) begin
      vcount++;
      if (first_valid < 0) first_valid = k;
    end
    if (frame_err) ecount++;
    if (busy) bcount++;
  endtask

  task automatic play();
    for (int k = 0; k < line.size(); k++) begin
      rx = line[k];
      @(posedge clk);
      #1 compare(k);
      #1;
    end
  endtask

  task automatic run_scn();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    build_model();
    play();
  endtask

  initial begin
    bit [7:0] b;
    int kind;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 32'(0));
    check("rst_valid", 32'(data_valid), 32'(0));
    check("rst_err", 32'(frame_err), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));

    // idle line for three frame times
    line.delete();
    idle(30*CBP + 4);
    run_scn();
    check("idle_valids", 32'(vcount), 32'(0));
    check("idle_errs", 32'(ecount), 32'(0));
    check("idle_busy", 32'(bcount), 32'(0));

    // single frame A5
    line.delete();
    idle(4); frame(8'hA5, 1'b1); idle(40);
    run_scn();
    check("a5_model_time", 32'(ev[158]), 32'(1));
    check("a5_model_data", 32'(evd[158]), 32'(8'hA5));
    check("a5_time", 32'(first_valid), 32'(158));
    check("a5_count", 32'(vcount), 32'(1));
    check("a5_data", 32'(data_out), 32'(8'hA5));

    // back-to-back frames, no gap
    line.delete();
    idle(4);
    frame(8'h00, 1'b1); frame(8'hFF, 1'b1); frame(8'h3C, 1'b1);
    idle(40);
    run_scn();
    check("b2b_count", 32'(vcount), 32'(3));
    check("b2b_errs", 32'(ecount), 32'(0));
    check("b2b_last", 32'(data_out), 32'(8'h3C));

    // good frame, bad stop with held break, then good frame
    line.delete();
    idle(4);
    frame(8'h12, 1'b1);
    frame(8'h55, 1'b0);
    low(2*CBP);
    idle(2*CBP);
    frame(8'h81, 1'b1);
    idle(40);
    run_scn();
    check("ferr_model", 32'(ev[318]), 32'(2));
    check("ferr_errs", 32'(ecount), 32'(1));
    check("ferr_valids", 32'(vcount), 32'(2));
    check("ferr_data", 32'(data_out), 32'(8'h81));

    // short glitch rejected
    line.delete();
    idle(4); low(3); idle(40);
    run_scn();
    check("glitch_model_busy", 32'(eb[6]), 32'(1));
    check("glitch_model_idle", 32'(eb[4+HALF+3]), 32'(0));
    check("glitch_valids", 32'(vcount), 32'(0));
    check("glitch_busy_end", 32'(busy), 32'(0));

    // reset in the middle of data bit 4
    line.delete();
    idle(4); frame(8'h5A, 1'b1);
    low(CBP); idle(CBP); low(CBP);
    idle(2*CBP); low(CBP/2);
    run_scn();
    check("mid_pre_data", 32'(data_out), 32'(8'h5A));
    check("mid_pre_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_out), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_valid", 32'(data_valid), 32'(0));
    check("mid_rst_err", 32'(frame_err), 32'(0));
    line.delete();
    idle(4); frame(8'h7E, 1'b1); idle(40);
    run_scn();
    check("after_rst_time", 32'(first_valid), 32'(158));
    check("after_rst_data", 32'(data_out), 32'(8'h7E));

    // one-cycle spike at the centre of each data bit
    line.delete();
    idle(4); frame(8'hC3, 1'b1); idle(40);
    for (int i = 0; i < 8; i++)
      line[4 + HALF + (i+1)*CBP] = ~line[4 + HALF + (i+1)*CBP];
    run_scn();
`ifdef UART_RX_MAJORITY_EN
    check("spike_model", 32'(evd[158]), 32'(8'hC3));
    check("spike_data", 32'(data_out), 32'(8'hC3));
`else
    check("spike_model", 32'(evd[158]), 32'(8'h3C));
    check("spike_data", 32'(data_out), 32'(8'h3C));
`endif

    // randomized traffic: good frames, bad stops, glitches
    line.delete();
    idle(5);
    while (line.size() < MAXT - 400) begin
      kind = int'($urandom_range(0, 5));
      b = 8'($urandom);
      if (kind == 0) begin
        low(int'($urandom_range(1, HALF + 3)));
        idle(int'($urandom_range(CBP, 2*CBP)));
      end else if (kind == 1) begin
        frame(b, 1'b0);
        low(int'($urandom_range(0, 2*CBP)));
        idle(int'($urandom_range(1, CBP)));
      end else begin
        frame(b, 1'b1);
        idle(int'($urandom_range(0, 6)));
      end
    end
    idle(3*CBP);
    run_scn();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
